// File: rtl/sobel_window_gen.sv
// 3x3 window generator for the Sobel core: two line buffers plus three pixels,
// one window per raster centre, border centres flagged and zeroed.
module sobel_window_gen #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  output logic          out_valid,
  output logic [DW-1:0] p0,
  output logic [DW-1:0] p1,
  output logic [DW-1:0] p2,
  output logic [DW-1:0] p3,
  output logic [DW-1:0] p5,
  output logic [DW-1:0] p6,
  output logic [DW-1:0] p7,
  output logic [DW-1:0] p8,
  output logic          border,
  output logic          out_last
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int IW   = $clog2(NPIX + 1);
  localparam int RW   = $clog2(HEIGHT);
  localparam int CW   = $clog2(WIDTH);
  localparam int DL   = 2 * WIDTH + 2;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t        r_state;
  logic          r_in_ready;
  logic [IW-1:0] r_in_idx;
  logic [IW-1:0] r_out_idx;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [DW-1:0] r_dl [DL];

  logic          w_acc;
  logic          w_abort;
  logic          w_flush;
  logic          w_shift;
  logic          w_emit;
  logic          w_edge;
  logic          w_end;
  logic [DW-1:0] w_new;

  assign in_ready = r_in_ready;
  assign w_acc    = in_valid & r_in_ready;
  assign w_abort  = w_acc & in_sof & (r_in_idx != '0);
  assign w_flush  = (r_state == FLUSH);
  assign w_shift  = w_acc | w_flush;
  assign w_emit   = (w_acc & ~w_abort & (r_state == RUN)) | w_flush;
  assign w_new    = w_flush ? '0 : in_data;
  assign w_end    = (r_out_idx == IW'(NPIX - 1));
  assign w_edge   = (r_row == '0) | (r_row == RW'(HEIGHT - 1)) |
                    (r_col == '0) | (r_col == CW'(WIDTH - 1));

  // Taps below are read one position early: they see the post-shift line.
  always_ff @(posedge clk) begin
    if (w_shift) begin
      r_dl[0] <= w_new;
      for (int i = 1; i < DL; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_in_ready <= 1'b1;
      r_in_idx   <= '0;
      r_out_idx  <= '0;
      r_row      <= '0;
      r_col      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      border     <= 1'b0;
      p0 <= '0; p1 <= '0; p2 <= '0; p3 <= '0;
      p5 <= '0; p6 <= '0; p7 <= '0; p8 <= '0;
    end else begin
      out_valid <= w_emit;
      out_last  <= w_emit & w_end;
      if (w_emit) begin
        border <= w_edge;
        p8 <= w_edge ? '0 : w_new;
        p7 <= w_edge ? '0 : r_dl[0];
        p6 <= w_edge ? '0 : r_dl[1];
        p5 <= w_edge ? '0 : r_dl[WIDTH-1];
        p3 <= w_edge ? '0 : r_dl[WIDTH+1];
        p2 <= w_edge ? '0 : r_dl[2*WIDTH-1];
        p1 <= w_edge ? '0 : r_dl[2*WIDTH];
        p0 <= w_edge ? '0 : r_dl[2*WIDTH+1];
        r_out_idx <= w_end ? '0 : r_out_idx + 1'b1;
        if (r_col == CW'(WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      unique case (r_state)
        FILL, RUN: begin
          if (w_abort) begin
            r_state   <= FILL;
            r_in_idx  <= IW'(1);
            r_out_idx <= '0;
            r_row     <= '0;
            r_col     <= '0;
          end else if (w_acc) begin
            r_in_idx <= r_in_idx + 1'b1;
            if (r_state == FILL && r_in_idx == IW'(WIDTH))
              r_state <= RUN;
            if (r_state == RUN && r_in_idx == IW'(NPIX - 1)) begin
              r_state    <= FLUSH;
              r_in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (w_end) begin
            r_state    <= FILL;
            r_in_ready <= 1'b1;
            r_in_idx   <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: image-array window model checked every cycle,
// plus literal pins on the first window and centre (1,1).
module tb_sobel_window_gen;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int OFF [8] = '{0, 1, 2, 8, 10, 16, 17, 18};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_sof = 1'b0;
  logic       out_valid;
  logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic       border;
  logic       out_last;

  sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .border(border), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_chk = 0;
  int cur_base = 0;

  int img [NPIX];
  int cnt = 0;
  int fl = 0;
  bit m_ready = 1;
  bit m_restart = 0;
  bit exp_valid = 0;
  bit exp_last = 0;
  bit exp_border = 0;
  int exp_k = 0;
  int exp_base = 0;
  int exp_p [8] = '{default: 0};

  int dut_cnt = 0;
  int frames_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic emit(input int k);
    int r, c;
    r = k / W;
    c = k % W;
    exp_valid  = 1;
    exp_k      = k;
    exp_last   = (k == NPIX - 1);
    exp_base   = cur_base;
    exp_border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    if (exp_border) begin
      exp_p = '{default: 0};
    end else begin
      exp_p[0] = img[(r-1)*W + c-1];
      exp_p[1] = img[(r-1)*W + c];
      exp_p[2] = img[(r-1)*W + c+1];
      exp_p[3] = img[r*W + c-1];
      exp_p[4] = img[r*W + c+1];
      exp_p[5] = img[(r+1)*W + c-1];
      exp_p[6] = img[(r+1)*W + c];
      exp_p[7] = img[(r+1)*W + c+1];
    end
  endtask

  // Model: which centre (if any) must appear after this edge.
  always @(posedge clk) begin
    exp_valid = 0;
    m_restart = 0;
    if (rst) begin
      m_ready    = 1;
      cnt        = 0;
      fl         = 0;
      exp_border = 0;
      exp_p      = '{default: 0};
      m_restart  = 1;
    end else if (!m_ready) begin
      emit(NPIX - fl);
      fl--;
      if (fl == 0) begin
        m_ready = 1;
        cnt     = 0;
      end
    end else if (in_valid) begin
      if (in_sof && cnt != 0) begin
        img[0]    = int'(in_data);
        cnt       = 1;
        m_restart = 1;
      end else begin
        img[cnt] = int'(in_data);
        if (cnt >= W + 1) emit(cnt - W - 1);
        if (cnt == NPIX - 1) begin
          m_ready = 0;
          fl      = W + 1;
        end
        cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      int act [8];
      act = '{int'(p0), int'(p1), int'(p2), int'(p3),
              int'(p5), int'(p6), int'(p7), int'(p8)};
      if (m_restart) dut_cnt = 0;
      chk("in_ready", int'(in_ready), int'(m_ready));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("border", int'(border), int'(exp_border));
      for (int i = 0; i < 8; i++) chk($sformatf("p_tap%0d", i), act[i], exp_p[i]);
      if (exp_valid) begin
        chk("out_last", int'(out_last), int'(exp_last));
        if (exp_k == 0) begin
          chk("first_border", int'(border), 1);
          for (int i = 0; i < 8; i++) chk("first_zero", act[i], 0);
        end
        if (exp_k == 9) begin
          chk("c11_border", int'(border), 0);
          for (int i = 0; i < 8; i++)
            chk($sformatf("c11_tap%0d", i), act[i], (exp_base + OFF[i]) % 256);
        end
      end
      if (out_valid) dut_cnt++;
      if (out_valid && out_last) begin
        chk("frame_windows", dut_cnt, NPIX);
        dut_cnt = 0;
        frames_done++;
      end
    end
  end

  task automatic send_frame(input int base, input int npx, input bit gaps);
    int g;
    for (int i = 0; i < npx; i++) begin
      @(negedge clk);
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 0;
          @(negedge clk);
        end
      end
      cur_base = base;
      in_valid = 1;
      in_data  = 8'((base + i) % 256);
      in_sof   = (i == 0);
      g = 0;
      while (!in_ready && g < 64) begin
        @(negedge clk);
        g++;
      end
      chk("ready_wait", int'(in_ready), 1);
    end
    @(negedge clk);
    in_valid = 0;
    in_sof   = 0;
  endtask

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    run_chk = 1;
    @(negedge clk);
    rst = 0;

    send_frame(0, NPIX, 0);
    send_frame(0, NPIX, 1);
    send_frame(0, 20, 0);
    send_frame(100, NPIX, 0);
    send_frame(0, 30, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    send_frame(0, NPIX, 0);

    for (int i = 0; i < 100 && frames_done < 4; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("frames_done", frames_done, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Hardware producer of the 3x3 neighbourhood bus (p0..p3, p5..p8) consumed by top_level.
- Takes a raster-order 8-bit pixel stream and buffers two lines plus three pixels.
- Emits one window per pixel centre in raster order; frame-border centres are flagged and their window is zeroed.
- Sits between the camera/frame-read path and the Sobel core, replacing the software-side window construction.

Parameters:
- WIDTH, 640, pixels per line (>=4)
- HEIGHT, 480, lines per frame (>=3)
- DW, 8, pixel width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts pixel this cycle (accept = in_valid & in_ready)
- in_data  in  DW  input pixel, raster order
- in_sof  in  1  start of frame; qualified by accept, marks pixel index 0
- out_valid  out  1  window valid, single-cycle per centre
- p0,p1,p2,p3,p5,p6,p7,p8  out  DW each  neighbours of centre (r,c): p0=(r-1,c-1), p1=(r-1,c), p2=(r-1,c+1), p3=(r,c-1), p5=(r,c+1), p6=(r+1,c-1), p7=(r+1,c), p8=(r+1,c+1)
- border  out  1  centre is on row 0, row HEIGHT-1, col 0 or col WIDTH-1
- out_last  out  1  with out_valid, centre index WIDTH*HEIGHT-1

Behaviour:
- Reset: state FILL; in_ready=1; out_valid, border, out_last, and all p* = 0; counters in_idx=0 and out_idx=0; delay line contents don't-care.
- Delay line D[0..2*WIDTH+2]: D[0] is the newest pixel. Each shift moves D[i] to D[i+1]. Shift on accept (in_data) and on every FLUSH cycle (zero).
- Taps: p8=D[0], p7=D[1], p6=D[2], p5=D[WIDTH], p3=D[WIDTH+2], p2=D[2*WIDTH], p1=D[2*WIDTH+1], p0=D[2*WIDTH+2].
- Taps are sampled after the shift, i.e. the newest pixel is the bottom-right of the window.
- Centre of the window = input index minus (WIDTH+1).
- FSM states:
  - FILL: in_ready=1; accept increments in_idx; no output. Moves to RUN when the accepted index is WIDTH (so WIDTH+1 pixels are held).
  - RUN: in_ready=1; each accept produces one output the next cycle for centre out_idx, then out_idx increments. On accept of index WIDTH*HEIGHT-1, go to FLUSH.
  - FLUSH: in_ready=0; emits one output per cycle for the remaining WIDTH+1 centres; in_valid is ignored. After the output with out_last, go to FILL with counters cleared.
- Output register: out_valid, p*, border and out_last are all registered; latency is 1 cycle from the triggering accept or flush cycle.
  - out_valid=0 in cycles with no trigger.
  - p* and border hold their last values while out_valid=0.
- Border rule: when border=1, all eight p* = 0. Otherwise p* = taps.
  - All FLUSH outputs are border (centres lie in the last column or last row).
  - Delay-line zero fill is therefore never visible.
- Row/col of the centre are tracked as counters, not division. col wraps at WIDTH-1 (row increments); out_idx wraps at frame end.
- in_sof:
  - Accepted in_sof with in_idx!=0 in FILL/RUN aborts the frame.
  - That pixel becomes index 0 and counters reset; state becomes FILL with in_idx=1.
  - No outputs are produced for the aborted frame's pending centres.
  - Stale delay-line data is never visible: row-0 outputs are border.
  - in_sof at index 0 is a no-op. in_sof is not required; frames also self-delimit by count.
- Reset mid-frame: returns to the reset state next cycle. The current frame is discarded and no out_valid is issued.
- Exactly WIDTH*HEIGHT out_valid pulses per complete frame, in raster order of centre.
- Input gaps (in_valid=0) in FILL/RUN stall without output. FLUSH is never stalled (no output backpressure).

Test Plan (WIDTH=8, HEIGHT=6, pixel = index mod 256, in_sof on index 0, in_valid continuous):
- Reset then stream -> first out_valid 1 cycle after accept of index 9: centre 0, border=1, all p*=0.
- Interior centre (1,1) -> on output triggered by accept of index 18: p0=0,p1=1,p2=2,p3=8,p5=10,p6=16,p7=17,p8=18, border=0.
- Last input index 47 accepted -> in_ready=0 for 9 cycles; 9 border outputs; out_last=1 on the final one; 48 out_valid total; then in_ready=1 in FILL.
- in_valid toggled pseudo-randomly -> same 48 windows in the same order and values as the continuous run; no output in gap cycles.
- in_sof reasserted at index 20 with a new ramp starting at 100 -> no further outputs for the old frame; new frame yields 48 windows; centre (1,1) = p0=100 … p8=118.
- rst pulsed at index 30 -> out_valid=0 and p*=0 next cycle; a fresh frame afterwards produces the full, correct 48 windows.
